uart_frame_parser: RTL and testbench

- Sits directly downstream of the UART receiver; consumes its single-cycle byte strobes.
- Finds framed packets: SYNC, LEN, LEN payload bytes, CHECKSUM.
- Buffers the payload, validates length and checksum, then streams good payloads out on a valid/ready interface.
- Reports framing errors as one-cycle pulses.

---
 rtl/uart_frame_parser.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// -----------------------------------------------------------------------------
// uart_frame_parser
//
// Purpose:
//   Sits behind a UART receiver and extracts framed packets of the form
//     SYNC, LEN, LEN payload bytes, CHECKSUM
//   The checksum is the 8-bit sum of LEN and all payload bytes. Payloads are
//   buffered and only streamed out once the checksum has been confirmed, so a
//   consumer never sees bytes from a corrupt frame. Framing problems are
//   reported as one-cycle error pulses.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   byte_valid    in   one-cycle strobe from the UART receiver (no backpressure)
//   byte_in[7:0]  in   received byte, meaningful when byte_valid=1
//   out_valid     out  payload byte available
//   out_ready     in   consumer ready
//   out_data[7:0] out  payload byte
//   out_last      out  final payload byte of the frame
//   err_len       out  pulse: LEN was 0 or above MAX_LEN
//   err_checksum  out  pulse: checksum mismatch
//   err_timeout   out  pulse: mid-frame silence exceeded the timeout
//   err_overrun   out  pulse: byte arrived (and was dropped) while draining
//   frame_count   out  good-frame counter, wraps at 2^16
//
// Handshake: a payload byte transfers on every rising clk edge where
// out_valid && out_ready. Once out_valid is raised, out_data/out_last stay
// stable and out_valid stays high until that transfer happens.
// -----------------------------------------------------------------------------
module uart_frame_parser #(
    parameter int         INPUT_CLOCK_FREQ = 100_000_000,
    parameter int         BAUD_RATE        = 9600,
    parameter int         TIMEOUT_BITS     = 20,
    parameter logic [7:0] SYNC_BYTE        = 8'hA5,
    parameter int         MAX_LEN          = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        err_len,
    output logic        err_checksum,
    output logic        err_timeout,
    output logic        err_overrun,
    output logic [15:0] frame_count
);

    localparam int TIMEOUT_CYCLES = (INPUT_CLOCK_FREQ / BAUD_RATE) * TIMEOUT_BITS;
    localparam int TW             = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int IW             = $clog2(MAX_LEN + 1);
    // Buffer is sized to the full index range so idx+1 lookahead reads are
    // always in bounds.
    localparam int DEPTH          = 1 << IW;
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CSUM    = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_len, w_len_nxt;
    logic [IW-1:0] r_idx, w_idx_nxt;
    logic [7:0]    r_sum, w_sum_nxt;
    logic [TW-1:0] r_to_cnt, w_to_cnt_nxt;
    logic          r_out_valid, w_out_valid_nxt;
    logic [7:0]    r_out_data, w_out_data_nxt;
    logic          r_out_last, w_out_last_nxt;
    logic          r_err_len, w_err_len_nxt;
    logic          r_err_checksum, w_err_checksum_nxt;
    logic          r_err_timeout, w_err_timeout_nxt;
    logic          r_err_overrun, w_err_overrun_nxt;
    logic [15:0]   r_frame_count, w_frame_count_nxt;

    logic          w_buf_we;
    logic [IW-1:0] w_idx_inc;
    logic          w_in_frame;
    logic [7:0]    r_buf [0:DEPTH-1];

    assign w_idx_inc  = r_idx + 1'b1;
    assign w_in_frame = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CSUM);

    // Payload storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[r_idx] <= byte_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_HUNT;
            r_len          <= '0;
            r_idx          <= '0;
            r_sum          <= '0;
            r_to_cnt       <= '0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_last     <= 1'b0;
            r_err_len      <= 1'b0;
            r_err_checksum <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_overrun  <= 1'b0;
            r_frame_count  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_len          <= w_len_nxt;
            r_idx          <= w_idx_nxt;
            r_sum          <= w_sum_nxt;
            r_to_cnt       <= w_to_cnt_nxt;
            r_out_valid    <= w_out_valid_nxt;
            r_out_data     <= w_out_data_nxt;
            r_out_last     <= w_out_last_nxt;
            r_err_len      <= w_err_len_nxt;
            r_err_checksum <= w_err_checksum_nxt;
            r_err_timeout  <= w_err_timeout_nxt;
            r_err_overrun  <= w_err_overrun_nxt;
            r_frame_count  <= w_frame_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_len_nxt          = r_len;
        w_idx_nxt          = r_idx;
        w_sum_nxt          = r_sum;
        w_to_cnt_nxt       = r_to_cnt;
        w_out_valid_nxt    = r_out_valid;
        w_out_data_nxt     = r_out_data;
        w_out_last_nxt     = r_out_last;
        w_err_len_nxt      = 1'b0;
        w_err_checksum_nxt = 1'b0;
        w_err_timeout_nxt  = 1'b0;
        w_err_overrun_nxt  = 1'b0;
        w_frame_count_nxt  = r_frame_count;
        w_buf_we           = 1'b0;

        // Inter-byte silence tracking while a frame is being collected. A byte
        // on the expiry cycle takes priority and is handled in the case below.
        if (w_in_frame && !byte_valid) begin
            if (r_to_cnt == TO_LAST) begin
                w_err_timeout_nxt = 1'b1;
                w_state_nxt       = S_HUNT;
                w_to_cnt_nxt      = '0;
            end else begin
                w_to_cnt_nxt = r_to_cnt + 1'b1;
            end
        end

        case (r_state)
            S_HUNT: begin
                if (byte_valid && (byte_in == SYNC_BYTE)) begin
                    w_state_nxt  = S_LEN;
                    w_to_cnt_nxt = '0;
                end
            end

            S_LEN: begin
                if (byte_valid) begin
                    w_to_cnt_nxt = '0;
                    if ((byte_in == 8'd0) || (byte_in > MAX_LEN_B)) begin
                        w_err_len_nxt = 1'b1;
                        w_state_nxt   = S_HUNT;
                    end else begin
                        w_len_nxt   = byte_in[IW-1:0];
                        w_sum_nxt   = byte_in;
                        w_idx_nxt   = '0;
                        w_state_nxt = S_PAYLOAD;
                    end
                end
            end

            S_PAYLOAD: begin
                if (byte_valid) begin
                    w_to_cnt_nxt = '0;
                    w_buf_we     = 1'b1;
                    w_sum_nxt    = r_sum + byte_in;
                    w_idx_nxt    = w_idx_inc;
                    if (w_idx_inc == r_len) begin
                        w_state_nxt = S_CSUM;
                    end
                end
            end

            S_CSUM: begin
                if (byte_valid) begin
                    w_to_cnt_nxt = '0;
                    if (byte_in == r_sum) begin
                        // Present the first payload byte straight away.
                        w_frame_count_nxt = r_frame_count + 16'd1;
                        w_idx_nxt         = '0;
                        w_out_valid_nxt   = 1'b1;
                        w_out_data_nxt    = r_buf[0];
                        w_out_last_nxt    = (r_len == IW'(1));
                        w_state_nxt       = S_DRAIN;
                    end else begin
                        w_err_checksum_nxt = 1'b1;
                        w_state_nxt        = S_HUNT;
                    end
                end
            end

            S_DRAIN: begin
                // No capture while draining: every incoming byte is lost.
                if (byte_valid) begin
                    w_err_overrun_nxt = 1'b1;
                end
                if (r_out_valid && out_ready) begin
                    if (r_out_last) begin
                        w_out_valid_nxt = 1'b0;
                        w_out_last_nxt  = 1'b0;
                        w_state_nxt     = S_HUNT;
                    end else begin
                        w_idx_nxt      = w_idx_inc;
                        w_out_data_nxt = r_buf[w_idx_inc];
                        w_out_last_nxt = (w_idx_inc == (r_len - 1'b1));
                    end
                end
            end

            default: begin
                w_state_nxt = S_HUNT;
            end
        endcase
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_last     = r_out_last;
    assign err_len      = r_err_len;
    assign err_checksum = r_err_checksum;
    assign err_timeout  = r_err_timeout;
    assign err_overrun  = r_err_overrun;
    assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_uart_frame_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_parser
//
// Directed bench for uart_frame_parser. Stimulus tasks push expected payload
// bytes ({last, data}) and expected error pulses into queues; a monitor on the
// falling edge pops and compares whenever the DUT transfers a byte or raises
// an error pulse. The timeout is shortened to 20 cycles via parameters.
// -----------------------------------------------------------------------------
module tb_uart_frame_parser;

    localparam int         CLK_HZ  = 1000;
    localparam int         BAUD    = 100;
    localparam int         TO_BITS = 2;
    localparam int         TC      = (CLK_HZ / BAUD) * TO_BITS;   // 20 cycles
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         MAXL    = 16;

    // error code bit order: {overrun, timeout, checksum, len}
    localparam logic [3:0] E_LEN  = 4'b0001;
    localparam logic [3:0] E_CSUM = 4'b0010;
    localparam logic [3:0] E_TO   = 4'b0100;
    localparam logic [3:0] E_OVR  = 4'b1000;

    logic        clk;
    logic        rst_n;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        err_len;
    logic        err_checksum;
    logic        err_timeout;
    logic        err_overrun;
    logic [15:0] frame_count;

    logic [8:0] exp_q[$];
    logic [3:0] exp_err_q[$];
    int         n_cmp;
    int         n_mis;
    int         exp_frames;
    logic [8:0] mon_e;
    logic [3:0] mon_err;
    logic [3:0] mon_err_exp;

    uart_frame_parser #(
        .INPUT_CLOCK_FREQ (CLK_HZ),
        .BAUD_RATE        (BAUD),
        .TIMEOUT_BITS     (TO_BITS),
        .SYNC_BYTE        (SYNC),
        .MAX_LEN          (MAXL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_valid   (byte_valid),
        .byte_in      (byte_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .err_len      (err_len),
        .err_checksum (err_checksum),
        .err_timeout  (err_timeout),
        .err_overrun  (err_overrun),
        .frame_count  (frame_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_valid"}, out_valid, 0);
        chk({name, "_data"}, out_data, 0);
        chk({name, "_last"}, out_last, 0);
        chk({name, "_errs"}, {err_overrun, err_timeout, err_checksum, err_len}, 0);
        chk({name, "_fcnt"}, frame_count, 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_out: got data %0h last %0b with nothing expected (t=%0t)",
                             out_data, out_last, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", out_data, mon_e[7:0]);
                    chk("out_last", out_last, mon_e[8]);
                end
            end
            mon_err = {err_overrun, err_timeout, err_checksum, err_len};
            if (mon_err != 4'b0000) begin
                if (exp_err_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_err: got %b with nothing expected (t=%0t)", mon_err, $time);
                end else begin
                    mon_err_exp = exp_err_q.pop_front();
                    chk("err_kind", mon_err, mon_err_exp);
                end
            end
        end
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Good frame of n payload bytes base, base+1, ...; checksum from a model.
    task automatic send_good(input int n, input logic [7:0] base);
        logic [7:0] sum;
        logic [7:0] p;
        sum = 8'(n);
        send_byte(SYNC);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            p   = base + 8'(i);
            sum = sum + p;
            exp_q.push_back({(i == n - 1), p});
            send_byte(p);
        end
        exp_frames++;
        send_byte(sum);
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_bytes_left", exp_q.size(), 0);
        exp_q.delete();
        idle(2);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        n_cmp      = 0;
        n_mis      = 0;
        exp_frames = 0;
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        out_ready  = 1'b1;

        #12;
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Good frame, hand-computed checksum 03+11+22+33 = 69.
        send_byte(SYNC);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b1, 8'h33});
        exp_frames++;
        send_byte(8'h69);
        // Three consecutive beats, then valid drops.
        repeat (3) begin
            @(negedge clk);
            chk("t1_valid_run", out_valid, 1);
        end
        @(negedge clk);
        chk("t1_valid_end", out_valid, 0);
        @(posedge clk);
        #1;
        wait_drain(20);
        chk("t1_frame_count", frame_count, exp_frames);

        // Bad checksum, then a good frame.
        send_byte(SYNC);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        exp_err_q.push_back(E_CSUM);
        send_byte(8'h6A);
        idle(3);
        chk("t2_frame_count", frame_count, exp_frames);
        send_good(2, 8'h5A);
        wait_drain(20);
        chk("t2_frame_count_after", frame_count, exp_frames);

        // Length bounds: 0 and 17 rejected, 16 and 1 accepted.
        exp_err_q.push_back(E_LEN);
        send_byte(SYNC);
        send_byte(8'h00);
        idle(2);
        exp_err_q.push_back(E_LEN);
        send_byte(SYNC);
        send_byte(8'h11);
        idle(2);
        send_good(16, 8'h40);
        wait_drain(40);
        send_good(1, 8'hFE);
        wait_drain(20);
        chk("t3_frame_count", frame_count, exp_frames);

        // Timeout fires exactly TC cycles after the last byte.
        send_byte(SYNC);
        send_byte(8'h02);
        exp_err_q.push_back(E_TO);
        send_byte(8'h11);
        idle(TC - 1);
        chk("t4_to_early", err_timeout, 0);
        idle(1);
        chk("t4_to_pulse", err_timeout, 1);
        idle(1);
        chk("t4_to_width", err_timeout, 0);
        idle(2);

        // Byte on the expiry cycle wins; checksum 02+11+22 = 35.
        send_byte(SYNC);
        send_byte(8'h02);
        send_byte(8'h11);
        idle(TC - 1);
        send_byte(8'h22);
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h22});
        exp_frames++;
        send_byte(8'h35);
        wait_drain(20);
        chk("t4_frame_count", frame_count, exp_frames);

        // Backpressure with an overrun byte (a SYNC) dropped mid-drain.
        out_ready = 1'b0;
        send_byte(SYNC);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b1, 8'h33});
        exp_frames++;
        send_byte(8'h69);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", out_valid, 1);
            chk("t5_hold_data", out_data, 8'h11);
            chk("t5_hold_last", out_last, 0);
            if (i == 3) begin
                exp_err_q.push_back(E_OVR);
                byte_valid = 1'b1;
                byte_in    = SYNC;
            end else begin
                byte_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain(20);
        chk("t5_frame_count", frame_count, exp_frames);
        send_good(3, 8'h21);
        wait_drain(20);
        chk("t5_frame_count_after", frame_count, exp_frames);

        // Asynchronous reset mid-payload, off a clock edge.
        send_byte(SYNC);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        exp_frames = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h69);
        idle(2);
        chk("t6_garbage_ignored", frame_count, 0);
        send_good(3, 8'h11);
        wait_drain(20);
        chk("t6_frame_count", frame_count, exp_frames);

        idle(5);
        chk("err_expect_left", exp_err_q.size(), 0);
        chk("out_expect_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
